// File: rtl/pmu_lock_guard.sv
// Key-sequenced write lock for PMU control registers: KEY_A then KEY_B opens a
// single-use write window that closes after one grant, a stray key write, or TIMEOUT cycles.
module pmu_lock_guard #(
    parameter int                 NUM_REGS = 4,
    parameter int                 KEY_W    = 32,
    parameter logic [KEY_W-1:0]   KEY_A    = 32'h0051_F15E,
    parameter logic [KEY_W-1:0]   KEY_B    = 32'hFFAE_0EA1,
    parameter int                 TIMEOUT  = 16,
    parameter int                 VCNT_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                key_wr_valid,
    input  logic [KEY_W-1:0]    key_wr_data,
    input  logic [NUM_REGS-1:0] wr_valid,
    output logic [NUM_REGS-1:0] wr_grant,
    output logic                unlocked,
    output logic                violation,
    output logic [VCNT_W-1:0]   violation_cnt
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]       TLAST = TW'(TIMEOUT - 1);
    localparam logic [NUM_REGS-1:0] ONE   = NUM_REGS'(1);

    typedef enum logic [1:0] {LOCKED, ARMED, UNLOCKED} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                unlocked_q, unlocked_d;
    logic                violation_q, violation_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic [NUM_REGS-1:0] lowest;
    logic                multi_req;
    logic                any_req;

    assign lowest    = wr_valid & (~wr_valid + ONE);
    assign multi_req = (wr_valid & (wr_valid - ONE)) != '0;
    assign any_req   = wr_valid != '0;

    // Combinational grant; a key write in the same cycle cancels it.
    assign wr_grant = (state_q == UNLOCKED && !key_wr_valid && !reset) ? lowest : '0;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        violation_d = 1'b0;
        case (state_q)
            LOCKED: begin
                timer_d = '0;
                if (key_wr_valid) begin
                    if (key_wr_data == KEY_A) state_d = ARMED;
                    else violation_d = 1'b1;
                end
                if (any_req) violation_d = 1'b1;
            end
            ARMED: begin
                if (any_req) violation_d = 1'b1;
                if (key_wr_valid) begin
                    state_d = (key_wr_data == KEY_B) ? UNLOCKED : LOCKED;
                    if (key_wr_data != KEY_B) violation_d = 1'b1;
                end else if (timer_q == TLAST) begin
                    state_d = LOCKED;
                end
                timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
            end
            UNLOCKED: begin
                if (key_wr_valid) begin
                    state_d     = LOCKED;
                    violation_d = 1'b1;
                end else if (any_req) begin
                    state_d     = LOCKED;
                    violation_d = multi_req;
                end else if (timer_q == TLAST) begin
                    state_d = LOCKED;
                end
                timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
            end
            default: begin
                state_d = LOCKED;
                timer_d = '0;
            end
        endcase
        unlocked_d = (state_d == UNLOCKED);
        vcnt_d     = (violation_d && vcnt_q != '1) ? vcnt_q + 1'b1 : vcnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LOCKED;
            timer_q     <= '0;
            unlocked_q  <= 1'b0;
            violation_q <= 1'b0;
            vcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            unlocked_q  <= unlocked_d;
            violation_q <= violation_d;
            vcnt_q      <= vcnt_d;
        end
    end

    assign unlocked      = unlocked_q;
    assign violation     = violation_q;
    assign violation_cnt = vcnt_q;

endmodule

// File: tb/tb_pmu_lock_guard.sv
// Directed bench for pmu_lock_guard: unlock/write, multi-request, timeouts,
// aborts, reset mid-sequence and counter saturation.
module tb_pmu_lock_guard;

    localparam logic [31:0] KEY_A = 32'h0051_F15E;
    localparam logic [31:0] KEY_B = 32'hFFAE_0EA1;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_wr_valid;
    logic [31:0] key_wr_data;
    logic [3:0]  wr_valid;
    logic [3:0]  wr_grant;
    logic        unlocked;
    logic        violation;
    logic [7:0]  violation_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pmu_lock_guard dut (
        .clock(clock), .reset(reset),
        .key_wr_valid(key_wr_valid), .key_wr_data(key_wr_data),
        .wr_valid(wr_valid), .wr_grant(wr_grant),
        .unlocked(unlocked), .violation(violation), .violation_cnt(violation_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [31:0] d);
        key_wr_valid = 1'b1;
        key_wr_data  = d;
        tick();
        key_wr_valid = 1'b0;
        key_wr_data  = '0;
    endtask

    initial begin
        reset = 1'b1; key_wr_valid = 1'b0; key_wr_data = '0; wr_valid = '0;
        tick(); tick();
        chk("rst_unlocked", unlocked, 0);
        chk("rst_violation", violation, 0);
        chk("rst_cnt", violation_cnt, 0);

        // 1: write while locked
        reset = 1'b0; wr_valid = 4'b0001; #1;
        chk("t1_grant", wr_grant, 0);
        tick(); wr_valid = '0;
        chk("t1_viol", violation, 1);
        chk("t1_cnt", violation_cnt, 1);
        tick();
        chk("t1_viol_clr", violation, 0);

        // 2: unlock and single write
        key(KEY_A); key(KEY_B);
        chk("t2_unlocked", unlocked, 1);
        wr_valid = 4'b0100; #1;
        chk("t2_grant", wr_grant, 4'b0100);
        tick(); wr_valid = '0;
        chk("t2_relock", unlocked, 0);
        chk("t2_noviol", violation, 0);
        wr_valid = 4'b0100; #1;
        chk("t2_second_grant", wr_grant, 0);
        tick(); wr_valid = '0;
        chk("t2_second_viol", violation, 1);
        chk("t2_cnt", violation_cnt, 2);

        // 3: multiple requesters
        key(KEY_A); key(KEY_B);
        wr_valid = 4'b1010; #1;
        chk("t3_grant", wr_grant, 4'b0010);
        tick(); wr_valid = '0;
        chk("t3_viol", violation, 1);
        chk("t3_locked", unlocked, 0);
        chk("t3_cnt", violation_cnt, 3);

        // 4: ARMED timeout, then ARMED boundary, then UNLOCKED timeout
        key(KEY_A);
        repeat (16) tick();
        chk("t4_armed_to_noviol", violation, 0);
        key(KEY_B);
        chk("t4_late_keyb_viol", violation, 1);
        chk("t4_cnt", violation_cnt, 4);
        key(KEY_A);
        repeat (15) tick();
        key(KEY_B);
        chk("t4_keyb_at_edge", unlocked, 1);
        repeat (15) tick();
        chk("t4_unl_before_to", unlocked, 1);
        tick();
        chk("t4_unl_timeout", unlocked, 0);
        chk("t4_unl_to_noviol", violation, 0);

        // 5a: wrong second key
        key(KEY_A); key(32'h0);
        chk("t5_abort_viol", violation, 1);
        chk("t5_abort_locked", unlocked, 0);
        chk("t5_abort_cnt", violation_cnt, 5);
        tick();

        // 5b: reset in UNLOCKED
        key(KEY_A); key(KEY_B);
        chk("t5_unl", unlocked, 1);
        reset = 1'b1; wr_valid = 4'b0001; #1;
        chk("t5_rst_grant", wr_grant, 0);
        tick(); reset = 1'b0; wr_valid = '0;
        chk("t5_rst_unl", unlocked, 0);
        chk("t5_rst_cnt", violation_cnt, 0);
        key(KEY_B);
        chk("t5_partial_discard", violation, 1);
        chk("t5_partial_cnt", violation_cnt, 1);

        // key write beats register write in UNLOCKED
        key(KEY_A); key(KEY_B);
        key_wr_valid = 1'b1; key_wr_data = KEY_A; wr_valid = 4'b0001; #1;
        chk("kbw_grant", wr_grant, 0);
        tick(); key_wr_valid = 1'b0; wr_valid = '0;
        chk("kbw_locked", unlocked, 0);
        chk("kbw_viol", violation, 1);
        chk("kbw_cnt", violation_cnt, 2);

        // 6: saturation
        wr_valid = 4'b0001;
        repeat (253) tick();
        chk("t6_cnt_max", violation_cnt, 8'hFF);
        repeat (47) tick();
        wr_valid = '0;
        chk("t6_cnt_sat", violation_cnt, 8'hFF);
        chk("t6_viol_held", violation, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
